des_sweep_scheduler: RTL and testbench

DES_SWEEP_SCHEDULER -- requirements
Module: des_sweep_scheduler

---
 rtl/des_sweep_scheduler_pkg.sv | 38 +++
 rtl/des_sweep_scheduler_lane.sv | 89 ++++++++
 rtl/des_sweep_scheduler.sv | 157 +++++++++++++++
 tb/tb_des_sweep_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_sweep_scheduler_pkg.sv
// Shared types and field positions for the DES sweep scheduler and its lane controllers.
package des_sweep_scheduler_pkg;

  typedef enum logic [1:0] {
    TOP_IDLE,
    TOP_DISPATCH,
    TOP_WAIT_ALL,
    TOP_DONE
  } top_state_e;

  typedef enum logic [2:0] {
    LANE_FREE,
    LANE_CLEAR,
    LANE_RUN,
    LANE_DRAIN,
    LANE_COLLECT
  } lane_state_e;

  localparam int LANE_STATE_W  = 3;
  localparam int TOTAL_W       = 14;
  localparam int SEED_W        = 64;
  localparam int REGION_LSB    = 0;
  localparam int REGION_W      = 4;
  localparam int COUNTER_W     = 10;
  localparam int RUN_LEN_W     = 16;
  localparam int CMD_REGIONS_W = 5;

  localparam logic [CMD_REGIONS_W-1:0] MAX_REGIONS = 5'd16;

  function automatic logic [CMD_REGIONS_W-1:0] clamp_regions(input logic [CMD_REGIONS_W-1:0] r);
    return (r > MAX_REGIONS) ? MAX_REGIONS : r;
  endfunction

  function automatic logic [RUN_LEN_W-1:0] fix_run_len(input logic [RUN_LEN_W-1:0] l);
    return (l == '0) ? RUN_LEN_W'(1) : l;
  endfunction

endpackage

// File: rtl/des_sweep_scheduler_lane.sv
// Per-lane controller: clears the DES block, runs it for run_len cycles, then
// waits (bounded) for its result and holds it until the shared accumulator takes it.
module des_lane_ctrl
  import des_sweep_scheduler_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_i,
  input  logic [REGION_W-1:0]  region_i,
  input  logic [RUN_LEN_W-1:0] run_len_i,
  input  logic                 lane_valid_i,
  input  logic                 grant_i,
  output lane_state_e          state_o,
  output logic                 lane_rst_n_o,
  output logic                 lane_start_o,
  output logic [REGION_W-1:0]  region_o,
  output logic                 timeout_o
);

  localparam logic [RUN_LEN_W-1:0] TMO_LAST = RUN_LEN_W'(DRAIN_TIMEOUT - 1);

  lane_state_e          state_q, state_d;
  logic [RUN_LEN_W-1:0] cnt_q, cnt_d;
  logic [REGION_W-1:0]  region_q, region_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LANE_FREE;
      cnt_q    <= '0;
      region_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      region_q <= region_d;
    end
  end

  // cnt_q counts down the run length in RUN and counts drain cycles up in DRAIN.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    region_d     = region_q;
    lane_rst_n_o = rst_n;
    lane_start_o = 1'b0;
    timeout_o    = 1'b0;
    case (state_q)
      LANE_FREE: begin
        if (issue_i) begin
          state_d  = LANE_CLEAR;
          region_d = region_i;
          cnt_d    = run_len_i;
        end
      end
      LANE_CLEAR: begin
        lane_rst_n_o = 1'b0;
        state_d      = LANE_RUN;
      end
      LANE_RUN: begin
        lane_start_o = rst_n;
        if (cnt_q <= RUN_LEN_W'(1)) begin
          state_d = LANE_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - RUN_LEN_W'(1);
        end
      end
      LANE_DRAIN: begin
        if (lane_valid_i) begin
          state_d = LANE_COLLECT;
        end else if (cnt_q >= TMO_LAST) begin
          timeout_o = 1'b1;
          state_d   = LANE_FREE;
        end else begin
          cnt_d = cnt_q + RUN_LEN_W'(1);
        end
      end
      LANE_COLLECT: begin
        if (grant_i) state_d = LANE_FREE;
      end
      default: state_d = LANE_FREE;
    endcase
  end

  assign state_o  = state_q;
  assign region_o = region_q;

endmodule

// File: rtl/des_sweep_scheduler.sv
// Sweep scheduler: spreads a command's regions over NUM_LANES DES lanes and sums
// the lane counters into one total. Handshake: a command moves when cmd_valid & cmd_ready.
module des_sweep_scheduler
  import des_sweep_scheduler_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [CMD_REGIONS_W-1:0]          cmd_regions,
  input  logic [RUN_LEN_W-1:0]              cmd_run_len,
  output logic [NUM_LANES-1:0]              lane_rst_n,
  output logic [NUM_LANES-1:0]              lane_start,
  output logic [SEED_W*NUM_LANES-1:0]       lane_seed,
  input  logic [COUNTER_W*NUM_LANES-1:0]    lane_counter,
  input  logic [NUM_LANES-1:0]              lane_valid,
  output logic                              busy,
  output logic                              done,
  output logic [TOTAL_W-1:0]                total,
  output logic                              timeout_err,
  output top_state_e                        dbg_top_state,
  output logic [LANE_STATE_W*NUM_LANES-1:0] dbg_lane_state
);

  top_state_e               state_q, state_d;
  logic [CMD_REGIONS_W-1:0] regions_q, regions_d;
  logic [CMD_REGIONS_W-1:0] next_region_q, next_region_d;
  logic [RUN_LEN_W-1:0]     run_len_q, run_len_d;
  logic [TOTAL_W-1:0]       total_q, total_d;
  logic                     timeout_q, timeout_d;

  lane_state_e              lane_state [NUM_LANES];
  logic [REGION_W-1:0]      lane_region [NUM_LANES];
  logic [NUM_LANES-1:0]     issue, grant, lane_tmo;
  logic [COUNTER_W-1:0]     collect_val;
  logic                     all_free, found_free, found_coll;
  logic                     accept, dispatch_req, issued;
  logic [CMD_REGIONS_W-1:0] clamped_regions;
  logic [REGION_W-1:0]      issue_region;
  logic [RUN_LEN_W-1:0]     issue_run_len;

  assign cmd_ready       = rst_n & (state_q == TOP_IDLE);
  assign accept          = cmd_valid & cmd_ready;
  assign clamped_regions = clamp_regions(cmd_regions);

  // Region 0 goes out on the accepting edge itself so lane 0 is in CLEAR one cycle after accept.
  assign dispatch_req  = ((state_q == TOP_DISPATCH) && (next_region_q != regions_q)) ||
                         (accept && (clamped_regions != '0));
  assign issue_region  = (state_q == TOP_IDLE) ? '0 : next_region_q[REGION_W-1:0];
  assign issue_run_len = (state_q == TOP_IDLE) ? fix_run_len(cmd_run_len) : run_len_q;
  assign issued        = |issue;

  always_comb begin
    issue       = '0;
    grant       = '0;
    collect_val = '0;
    all_free    = 1'b1;
    found_free  = 1'b0;
    found_coll  = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_state[i] != LANE_FREE) all_free = 1'b0;
      if (!found_free && lane_state[i] == LANE_FREE) begin
        found_free = 1'b1;
        issue[i]   = dispatch_req;
      end
      if (!found_coll && lane_state[i] == LANE_COLLECT) begin
        found_coll  = 1'b1;
        grant[i]    = 1'b1;
        collect_val = lane_counter[i*COUNTER_W +: COUNTER_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= TOP_IDLE;
      regions_q     <= '0;
      next_region_q <= '0;
      run_len_q     <= RUN_LEN_W'(1);
      total_q       <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      regions_q     <= regions_d;
      next_region_q <= next_region_d;
      run_len_q     <= run_len_d;
      total_q       <= total_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    regions_d     = regions_q;
    next_region_d = next_region_q;
    run_len_d     = run_len_q;
    total_d       = total_q;
    timeout_d     = timeout_q;
    if (|grant)    total_d   = total_q + TOTAL_W'(collect_val);
    if (|lane_tmo) timeout_d = 1'b1;
    case (state_q)
      TOP_IDLE: begin
        if (accept) begin
          state_d       = TOP_DISPATCH;
          regions_d     = clamped_regions;
          run_len_d     = fix_run_len(cmd_run_len);
          total_d       = '0;
          timeout_d     = 1'b0;
          next_region_d = issued ? CMD_REGIONS_W'(1) : '0;
        end
      end
      TOP_DISPATCH: begin
        if (next_region_q == regions_q) begin
          state_d = TOP_WAIT_ALL;
        end else if (issued) begin
          next_region_d = next_region_q + CMD_REGIONS_W'(1);
        end
      end
      TOP_WAIT_ALL: begin
        if (all_free) state_d = TOP_DONE;
      end
      TOP_DONE: state_d = TOP_IDLE;
      default:  state_d = TOP_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    des_lane_ctrl #(
      .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_i      (issue[g]),
      .region_i     (issue_region),
      .run_len_i    (issue_run_len),
      .lane_valid_i (lane_valid[g]),
      .grant_i      (grant[g]),
      .state_o      (lane_state[g]),
      .lane_rst_n_o (lane_rst_n[g]),
      .lane_start_o (lane_start[g]),
      .region_o     (lane_region[g]),
      .timeout_o    (lane_tmo[g])
    );
    assign lane_seed[g*SEED_W +: SEED_W] = SEED_W'(lane_region[g]) << REGION_LSB;
    assign dbg_lane_state[g*LANE_STATE_W +: LANE_STATE_W] = lane_state[g];
  end

  assign busy          = rst_n & (state_q != TOP_IDLE);
  assign done          = rst_n & (state_q == TOP_DONE);
  assign total         = total_q;
  assign timeout_err   = timeout_q;
  assign dbg_top_state = state_q;

endmodule

// File: tb/tb_des_sweep_scheduler.sv
// Bench for des_sweep_scheduler: stub DES lanes, a region-order scoreboard and a
// sweep-level model of the expected total and timeout flag.
module tb_des_sweep_scheduler;
  import des_sweep_scheduler_pkg::*;

  localparam int NL  = 4;
  localparam int TMO = 64;

  // clock / reset / DUT
  logic              clk          = 1'b0;
  logic              rst_n        = 1'b0;
  logic              cmd_valid    = 1'b0;
  logic [4:0]        cmd_regions  = '0;
  logic [15:0]       cmd_run_len  = '0;
  logic [10*NL-1:0]  lane_counter = '0;
  logic [NL-1:0]     lane_valid   = '0;
  logic              cmd_ready, busy, done, timeout_err;
  logic [NL-1:0]     lane_rst_n, lane_start;
  logic [64*NL-1:0]  lane_seed;
  logic [13:0]       total;
  top_state_e        dbg_top_state;
  logic [3*NL-1:0]   dbg_lane_state;

  always #5 clk = ~clk;

  des_sweep_scheduler #(.NUM_LANES(NL), .DRAIN_TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_regions    (cmd_regions),
    .cmd_run_len    (cmd_run_len),
    .lane_rst_n     (lane_rst_n),
    .lane_start     (lane_start),
    .lane_seed      (lane_seed),
    .lane_counter   (lane_counter),
    .lane_valid     (lane_valid),
    .busy           (busy),
    .done           (done),
    .total          (total),
    .timeout_err    (timeout_err),
    .dbg_top_state  (dbg_top_state),
    .dbg_lane_state (dbg_lane_state)
  );

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [3:0]  exp_q[$];
  int          region_lane [16];
  int          first_clear_cyc = -1, first_start_cyc = -1, tmo_cyc = -1;
  int          done_cnt = 0, done_cyc = -1, n_start_cycles = 0;
  int          run_cnt [NL];
  int          drop_cyc [NL];
  int          exp_run = 1, exp_r = 0, acc_cyc = 0, d0 = 0;
  int          tot_cyc_q[$];
  int          tot_val_q[$];
  logic [13:0] last_total = '0;
  logic [63:0] sd;

  // stub lane configuration
  int          st_cnt [NL];
  logic        st_started [NL];
  int          st_delay [NL];
  logic        st_never [NL];
  int          stub_mode = 0;
  logic [9:0]  rand_tab [16];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int stub_value(input int mode, input int region, input int lane);
    case (mode)
      0:       return 100 + region;
      1:       return 1023;
      2:       return lane + 1;
      default: return int'(rand_tab[region]);
    endcase
  endfunction

  // monitor + stub lanes, sampled 1 time unit after each active edge
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < NL; i++) begin
      sd = lane_seed[i*64 +: 64];
      if (rst_n && !lane_rst_n[i]) begin
        if (first_clear_cyc < 0) first_clear_cyc = cyc;
        check_eq("seed_upper_zero", {4'h0, sd[63:4]}, 64'd0);
        check_eq("dispatch_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check_eq("dispatch_region", 64'(sd[3:0]), 64'(exp_q.pop_front()));
          region_lane[sd[3:0]] = i;
        end
      end
      if (lane_start[i]) begin
        run_cnt[i]++;
        n_start_cycles++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
      end else if (run_cnt[i] != 0) begin
        if (rst_n) check_eq("run_len", 64'(run_cnt[i]), 64'(exp_run));
        drop_cyc[i] = cyc;
        run_cnt[i]  = 0;
      end
      if (!rst_n || !lane_rst_n[i]) begin
        st_started[i] = 1'b0;
        st_cnt[i]     = 0;
        lane_valid[i] = 1'b0;
        lane_counter[i*10 +: 10] = '0;
      end else if (lane_start[i]) begin
        st_started[i] = 1'b1;
        st_cnt[i]     = 0;
      end else if (st_started[i] && !lane_valid[i] && !st_never[i]) begin
        st_cnt[i]++;
        if (st_cnt[i] >= st_delay[i]) begin
          lane_valid[i] = 1'b1;
          lane_counter[i*10 +: 10] = 10'(stub_value(stub_mode, int'(sd[3:0]), i));
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (total != last_total && total != '0) begin
      tot_cyc_q.push_back(cyc);
      tot_val_q.push_back(int'(total));
    end
    last_total = total;
    if (timeout_err && tmo_cyc < 0) tmo_cyc = cyc;
  end

  // driver tasks
  task automatic set_stub(input int mode, input int delay);
    stub_mode = mode;
    for (int i = 0; i < NL; i++) begin
      st_delay[i] = delay;
      st_never[i] = 1'b0;
    end
  endtask

  task automatic start_sweep(input int regions, input int run_len, input bit poke);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("ready_before_accept", 64'(cmd_ready), 64'd1);
    exp_r = (regions > 16) ? 16 : regions;
    exp_q.delete();
    for (int r = 0; r < exp_r; r++) exp_q.push_back(4'(r));
    for (int r = 0; r < 16; r++) region_lane[r] = -1;
    first_clear_cyc = -1;
    first_start_cyc = -1;
    tmo_cyc         = -1;
    n_start_cycles  = 0;
    tot_cyc_q.delete();
    tot_val_q.delete();
    exp_run     = (run_len == 0) ? 1 : run_len;
    cmd_regions = 5'(regions);
    cmd_run_len = 16'(run_len);
    cmd_valid   = 1'b1;
    acc_cyc     = cyc;
    d0          = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("busy_after_accept", 64'(busy), 64'd1);
    check_eq("ready_low_while_busy", 64'(cmd_ready), 64'd0);
    if (poke) begin
      cmd_regions = 5'd2;
      cmd_valid   = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic finish_sweep();
    int guard;
    int exp_total;
    bit exp_tmo;
    guard = 0;
    while (done_cnt == d0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("done_seen", 64'(done_cnt != d0), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check_eq("single_done", 64'(done_cnt - d0), 64'd1);
    exp_total = 0;
    exp_tmo   = 1'b0;
    for (int r = 0; r < exp_r; r++) begin
      if (region_lane[r] >= 0) begin
        if (st_never[region_lane[r]]) exp_tmo = 1'b1;
        else exp_total += stub_value(stub_mode, r, region_lane[r]);
      end
    end
    check_eq("total", 64'(total), 64'(exp_total));
    check_eq("timeout_err", 64'(timeout_err), 64'(exp_tmo));
    check_eq("all_regions_issued", 64'(exp_q.size()), 64'd0);
    check_eq("idle_not_busy", 64'(busy), 64'd0);
    check_eq("idle_ready", 64'(cmd_ready), 64'd1);
    if (exp_r > 0) begin
      check_eq("first_clear_cycle", 64'(first_clear_cyc), 64'(acc_cyc + 1));
      check_eq("first_start_cycle", 64'(first_start_cyc), 64'(acc_cyc + 2));
      for (int r = 0; r < exp_r && r < NL; r++)
        check_eq("first_wave_lane", 64'(region_lane[r]), 64'(r));
    end else begin
      check_eq("zero_region_done_cycle", 64'(done_cyc), 64'(acc_cyc + 3));
      check_eq("zero_region_no_start", 64'(n_start_cycles), 64'd0);
    end
  endtask

  int guard_r;

  initial begin
    for (int i = 0; i < NL; i++) begin
      run_cnt[i]    = 0;
      drop_cyc[i]   = 0;
      st_cnt[i]     = 0;
      st_started[i] = 1'b0;
    end
    for (int r = 0; r < 16; r++) rand_tab[r] = '0;
    set_stub(0, 20);

    // reset values
    repeat (3) @(negedge clk);
    check_eq("rst_lane_rst_n", 64'(lane_rst_n), 64'd0);
    check_eq("rst_lane_start", 64'(lane_start), 64'd0);
    check_eq("rst_lane_seed", lane_seed[63:0] | lane_seed[127:64] | lane_seed[191:128] | lane_seed[255:192], 64'd0);
    check_eq("rst_total", 64'(total), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_timeout_err", 64'(timeout_err), 64'd0);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 64'(cmd_ready), 64'd1);
    check_eq("post_rst_lane_rst_n", 64'(lane_rst_n), 64'hF);

    // 4 regions, counter = 100 + region
    set_stub(0, 20);
    start_sweep(4, 8, 1'b1);
    finish_sweep();

    // 16 regions, saturated counters
    set_stub(1, 5);
    start_sweep(16, 3, 1'b0);
    finish_sweep();

    // oversized region count clamps to 16
    set_stub(0, 2);
    start_sweep(31, 2, 1'b0);
    finish_sweep();

    // zero regions
    set_stub(0, 2);
    start_sweep(0, 5, 1'b0);
    finish_sweep();

    // run_len 0 behaves as 1
    set_stub(0, 1);
    start_sweep(3, 0, 1'b0);
    finish_sweep();

    // all four lanes valid in the same cycle: collected lane0..lane3 on consecutive cycles
    set_stub(2, 0);
    for (int i = 0; i < NL; i++) st_delay[i] = 10 - i;
    start_sweep(4, 6, 1'b0);
    finish_sweep();
    check_eq("collect_steps", 64'(tot_val_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < tot_val_q.size(); k++) begin
      check_eq("collect_running_total", 64'(tot_val_q[k]), 64'(k * (k + 1) / 2 + k + 1));
      check_eq("collect_consecutive", 64'(tot_cyc_q[k]), 64'(tot_cyc_q[0] + k));
    end

    // lane 2 never produces a result
    set_stub(0, 20);
    st_never[2] = 1'b1;
    start_sweep(4, 8, 1'b0);
    finish_sweep();
    check_eq("timeout_after_64_drain", 64'(tmo_cyc - drop_cyc[2]), 64'(TMO));

    // randomized sweeps
    for (int s = 0; s < 10; s++) begin
      stub_mode = 3;
      for (int r = 0; r < 16; r++) rand_tab[r] = 10'($urandom_range(0, 1023));
      for (int i = 0; i < NL; i++) begin
        st_delay[i] = $urandom_range(0, 40);
        st_never[i] = ($urandom_range(0, 5) == 0);
      end
      start_sweep($urandom_range(0, 20), $urandom_range(0, 12), (s % 2) == 1);
      finish_sweep();
    end

    // reset during RUN aborts the sweep
    set_stub(0, 20);
    start_sweep(4, 20, 1'b0);
    guard_r = 0;
    while (!lane_start[0] && guard_r < 20) begin
      @(negedge clk);
      guard_r++;
    end
    check_eq("run_reached", 64'(lane_start[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_lane_rst_n", 64'(lane_rst_n), 64'd0);
    check_eq("abort_lane_start", 64'(lane_start), 64'd0);
    check_eq("abort_lane_seed", lane_seed[63:0] | lane_seed[127:64] | lane_seed[191:128] | lane_seed[255:192], 64'd0);
    check_eq("abort_total", 64'(total), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_timeout_err", 64'(timeout_err), 64'd0);
    check_eq("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("abort_ready_after", 64'(cmd_ready), 64'd1);
    exp_q.delete();
    d0 = done_cnt;
    repeat (100) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check_eq("abort_idle", 64'(busy), 64'd0);

    // recovery sweep
    set_stub(0, 20);
    start_sweep(4, 8, 1'b0);
    finish_sweep();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
